muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit for the MIPS CPU execute stage, taking the MUL/MULU/MUH/MUHU/DIV/DIVU/MOD/MODU ops off the single-cycle combinational ALU path. It accepts one operation per start pulse and computes with a radix-2 shift-add or restoring-divide datapath over 32 iterations. It returns the 32-bit result with a one-cycle done pulse and holds it until the next accepted start. The pipeline stalls on busy.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only in IDLE
- op  in  6  operation code from common.v: ALU_OP_MUL, _MULU, _MUH, _MUHU, _DIV, _DIVU, _MOD, _MODU
- a  in  32  operand A / dividend; sampled on acceptance
- b  in  32  operand B / divisor; sampled on acceptance
- cancel  in  1  abort in-flight operation (pipeline flush)
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse in DONE; result valid
- result  out  32  result register, held until next accepted start
- div0  out  1  divide-op with b==0; valid with done, held like result

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 latches op, a, b and goes to CALC with iteration counter = 0. start=0 stays in IDLE.
- Unsupported op on start goes straight to DONE next cycle with result=0 and div0=0.
- Signed ops (MUL, MUH, DIV, MOD) operate on magnitudes; the sign is applied in FIX. Unsigned ops use operands unchanged.
- Multiply: 64-bit product accumulator, one shift-add per CALC cycle.
  - MUL and MULU return product[31:0].
  - MUH and MUHU return product[63:32].
  - Signed product is negated as a 64-bit value when the operand signs differ.
- Divide: restoring, one quotient bit per CALC cycle.
  - DIV and DIVU return the quotient; MOD and MODU return the remainder.
  - Signed quotient is negated when the signs differ. Signed remainder takes the dividend's sign, so the result truncates toward zero.
- CALC runs exactly 32 cycles (counter 0..31), then FIX (1 cycle), then DONE (1 cycle), then IDLE.
- Divide by zero runs the normal latency with no early exit.
  - Quotient = 0xFFFFFFFF and remainder = a, the natural unsigned restoring result.
  - Signed DIV by zero returns 0xFFFFFFFF with no sign fix; MOD by zero returns a.
  - div0=1 in all these cases.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): quotient = 0x80000000, MOD = 0. No trap.
- result and div0 update only on the FIX→DONE edge.

## Timing
- Reset (async): state=IDLE, busy=0, done=0, result=0, div0=0, counter=0.
- start high in IDLE in cycle 0:
  - busy=1 in cycles 1–33 (CALC 1–32, FIX 33).
  - done=1 in cycle 34; busy=0 in cycle 34.
  - IDLE in cycle 35.
- Latency is 34 cycles from acceptance to done, identical for every supported op including divide by zero. Unsupported op: done in cycle 1.
- start in CALC, FIX or DONE is ignored, not queued. Back-to-back throughput is one op per 35 cycles.
- cancel=1 in CALC or FIX: IDLE next cycle, no done, result/div0 keep old values. cancel in IDLE or DONE has no effect; DONE still pulses.
- start and cancel both high in IDLE: start accepted.
- rst mid-operation: immediate IDLE, all outputs to reset values, no done.
- Operand inputs may change freely after acceptance.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → done at cycle 34, result=0xFFFFFFEB. MUH a=b=0x80000000 → 0x40000000. MUHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. MOD same operands → 0xFFFFFFFF. DIVU a=0xFFFFFFFF, b=16 → 0x0FFFFFFF. MODU → 0x0000000F.
- DIVU a=0x1234, b=0 → result=0xFFFFFFFF, div0=1. MODU same → 0x1234, div0=1. Next MUL 2×3 → 6, div0=0.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. MOD → 0, div0=0.
- start held high for 40 cycles with changing operands → exactly one done at cycle 34 for the first operands, second acceptance at cycle 35.
- cancel at cycle 10 → no done, result unchanged. rst pulse at cycle 20 of a new op → busy=0, result=0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// 32 CALC cycles, one FIX cycle for sign correction, one-cycle done pulse.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div0
);

    localparam logic [5:0] ALU_OP_MUL  = 6'h18;
    localparam logic [5:0] ALU_OP_MULU = 6'h19;
    localparam logic [5:0] ALU_OP_MUH  = 6'h1A;
    localparam logic [5:0] ALU_OP_MUHU = 6'h1B;
    localparam logic [5:0] ALU_OP_DIV  = 6'h1C;
    localparam logic [5:0] ALU_OP_DIVU = 6'h1D;
    localparam logic [5:0] ALU_OP_MOD  = 6'h1E;
    localparam logic [5:0] ALU_OP_MODU = 6'h1F;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_reg;
    logic [4:0]  cnt_reg;
    logic        is_mul_reg;
    logic        sel_hi_reg;
    logic        neg_res_reg;
    logic        div0_pend_reg;
    logic [63:0] work_reg;
    logic [31:0] opnd_reg;
    logic [31:0] result_reg;
    logic        div0_reg;

    logic        dec_valid, dec_mul, dec_signed, dec_hi;
    logic [31:0] a_mag, b_mag;
    logic        neg_res_next;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] work_next;
    logic [63:0] prod_fixed;
    logic [31:0] div_sel;
    logic [31:0] fix_value;

    always_comb begin
        dec_valid  = 1'b1;
        dec_mul    = 1'b0;
        dec_signed = 1'b0;
        dec_hi     = 1'b0;
        case (op)
            ALU_OP_MUL:  begin dec_mul = 1'b1; dec_signed = 1'b1; end
            ALU_OP_MULU: begin dec_mul = 1'b1; end
            ALU_OP_MUH:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_hi = 1'b1; end
            ALU_OP_MUHU: begin dec_mul = 1'b1; dec_hi = 1'b1; end
            ALU_OP_DIV:  begin dec_signed = 1'b1; end
            ALU_OP_DIVU: begin end
            ALU_OP_MOD:  begin dec_signed = 1'b1; dec_hi = 1'b1; end
            ALU_OP_MODU: begin dec_hi = 1'b1; end
            default:     dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        a_mag = (dec_signed && a[31]) ? -a : a;
        b_mag = (dec_signed && b[31]) ? -b : b;
        // Remainder follows the dividend; a zero divisor leaves the quotient unfixed.
        if (dec_mul)
            neg_res_next = dec_signed & (a[31] ^ b[31]);
        else if (dec_hi)
            neg_res_next = dec_signed & a[31];
        else
            neg_res_next = dec_signed & (a[31] ^ b[31]) & (b != 32'd0);
    end

    // One iteration: multiply keeps {acc_hi, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, work_reg[63:32]} + (work_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        div_shift = {work_reg[63:32], work_reg[31]};
        div_ge    = div_shift[32] | (div_shift[31:0] >= opnd_reg);
        div_rem   = div_ge ? (div_shift[31:0] - opnd_reg) : div_shift[31:0];
        if (is_mul_reg)
            work_next = {mul_sum, work_reg[31:1]};
        else
            work_next = {div_rem, work_reg[30:0], div_ge};
    end

    always_comb begin
        prod_fixed = neg_res_reg ? -work_reg : work_reg;
        div_sel    = sel_hi_reg ? work_reg[63:32] : work_reg[31:0];
        if (is_mul_reg)
            fix_value = sel_hi_reg ? prod_fixed[63:32] : prod_fixed[31:0];
        else
            fix_value = neg_res_reg ? -div_sel : div_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 5'd0;
            is_mul_reg    <= 1'b0;
            sel_hi_reg    <= 1'b0;
            neg_res_reg   <= 1'b0;
            div0_pend_reg <= 1'b0;
            work_reg      <= 64'd0;
            opnd_reg      <= 32'd0;
            result_reg    <= 32'd0;
            div0_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (dec_valid) begin
                            state_reg     <= ST_CALC;
                            cnt_reg       <= 5'd0;
                            is_mul_reg    <= dec_mul;
                            sel_hi_reg    <= dec_hi;
                            neg_res_reg   <= neg_res_next;
                            div0_pend_reg <= ~dec_mul & (b == 32'd0);
                            work_reg      <= {32'd0, a_mag};
                            opnd_reg      <= b_mag;
                        end else begin
                            state_reg  <= ST_DONE;
                            result_reg <= 32'd0;
                            div0_reg   <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    if (cancel) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        work_reg <= work_next;
                        if (cnt_reg == 5'd31)
                            state_reg <= ST_FIX;
                        else
                            cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                ST_FIX: begin
                    if (cancel) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        result_reg <= fix_value;
                        div0_reg   <= div0_pend_reg;
                        state_reg  <= ST_DONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state_reg == ST_CALC) || (state_reg == ST_FIX);
    assign done   = (state_reg == ST_DONE);
    assign result = result_reg;
    assign div0   = div0_reg;

endmodule
